sap2_tstate_sequencer: RTL and testbench
========================================

// Module: sap2_tstate_sequencer
// PURPOSE
//  Front end of the SAP-2 control unit: 18-state one-hot T-state ring counter, instruction register, opcode decoder, zero-flag latch.
//  Drives the control matrix's T-state vector, one-hot instruction lines and zero flag; consumes its ring-reset and IR-load strobes.
//  Closes the sequencing loop: the matrix picks control words, this block steps T0..T17 and decodes the fetched opcode.
// PARAMETERS
//  NUM_T      18  ring counter length (T0..T17); fixed by the matrix, not for override
//  OPC_W      8   opcode/bus width
// PORTS
//  iClk        in   1      system clock, all state updates on rising edge
//  iRst        in   1      asynchronous, active-high; clears all state immediately
//  iBus        in   8      W-bus byte; opcode source for the IR
//  iLir        in   1      load IR from iBus this cycle (matrix asserts in T2)
//  iRingReset  in   1      return to T0 next edge (matrix end-of-instruction)
//  iLoadFlag   in   1      capture iZeroIn into zero flag
//  iZeroIn     in   1      ALU zero result
//  oTstate     out  18     one-hot T-state, bit n = Tn
//  oInstr      out  29     one-hot decoded instruction, index per sap2_pkg
//  oZeroFlag   out  1      registered zero flag
//  oHalted     out  1      HLT executed, sequencer frozen
//  oIllegal    out  1      sticky: an undefined opcode was decoded in T3
//  oSeqError   out  1      sticky: counter wrapped T17->T0 without iRingReset
// BEHAVIOUR
//  Reset values: oTstate=18'h00001 (T0), IR=8'h00 (oInstr = NOP bit only), oZeroFlag=0, oHalted=0, oIllegal=0, oSeqError=0.
//  Ring: each edge, iRingReset=1 -> T0; else shift left by one. T17 without iRingReset -> T0, set oSeqError.
//  oTstate always exactly one-hot; no other encoding reachable.
//  IR: iLir=1 -> IR<=iBus at edge; new decode visible the cycle after (T3 when loaded in T2). iLir and iRingReset same cycle: both apply.
//  Decode: combinational from IR; 29 defined opcodes (8085 encoding): NOP 00, STA 32, LDA 3A, INR A 3C, DCR A 3D, MVI A 3E,
//   RAL 17, RAR 1F, MOV B,A 47, MOV C,A 4F, HLT 76, MOV A,B 78, MOV A,C 79, ADD B/C 80/81, SUB B/C 90/91, ANA B/C A0/A1,
//   XRA B/C A8/A9, ORA B/C B0/B1, JMP C3, RET C9, JZ CA, CALL CD, OUT D3, IN DB.
//  Undefined opcode: oInstr drives NOP bit (matrix ends instruction at T3); oIllegal set when state is T3.
//  Halt: in T3 with HLT decoded -> oHalted=1 next edge, oTstate frozen at T4; iRingReset, iLir, iLoadFlag ignored while halted; only iRst exits.
//  Zero flag: iLoadFlag=1 -> oZeroFlag<=iZeroIn; otherwise holds. Independent of ring state.
//  iRst mid-instruction: immediate return to reset values, IR cleared; no partial state survives.
// CONFIGURATION
//  SAP2_SINGLE_STEP_EN defined: adds port iStep (in, 1). Ring, IR, flag and sticky updates occur only on edges with iStep=1;
//   iStep=0 holds all state. Halt and iRst behaviour unchanged.
//  Undefined: no iStep port; state advances every edge.
// STRUCTURE
//  sap2_pkg: opcode localparams (OPC_*), instruction index localparams (INSTR_* 0..28, alphabetical as matrix inputs), NUM_INSTR=29, NUM_T=18.
//  Sub-module sap2_opcode_decoder: pure combinational IR -> {oInstr, illegal}; sequencer instantiates one.
//  Top holds ring register, IR, flag, halted/sticky bits.
// TESTING
//  Reset then 5 clocks, iRingReset=0 -> oTstate 0x00001,0x00002,...,0x00020; oInstr=NOP bit.
//  iBus=8'h80, iLir in T2, iRingReset in T4 -> oInstr[INSTR_ADD_B]=1 from T3; oTstate=T0 after T4 edge.
//  18 clocks with no iRingReset -> T17 then T0, oSeqError=1 and stays 1.
//  Load 8'h76 in T2 -> oHalted=1 after T3 edge, oTstate stays T4 for 20 clocks despite iRingReset; iRst -> T0, oHalted=0.
//  Load 8'hFF -> oInstr=NOP bit, oIllegal=1 at T3; iRingReset at T3 -> T0 next edge.
//  iLoadFlag=1,iZeroIn=1 -> oZeroFlag=1; iLoadFlag=0,iZeroIn=0 -> holds 1; async iRst mid-cycle -> 0 immediately.
//  SAP2_SINGLE_STEP_EN: iStep low 10 clocks -> oTstate unchanged; iStep pulse -> one shift.

Source files
------------

// File: rtl/sap2_pkg.sv
// sap2_pkg: shared constants for the SAP-2 control-unit front end.
// Holds the 8085-style opcode values, the instruction-line indices (alphabetical,
// in the order the control matrix expects) and the T-state ring geometry.
package sap2_pkg;

  localparam int NUM_T     = 18;
  localparam int OPC_W     = 8;
  localparam int NUM_INSTR = 29;

  // T-states with special meaning to the sequencer
  localparam int T_DECODE = 3;  // first state in which the fetched opcode is decoded
  localparam int T_HALT   = 4;  // state the ring freezes in after HLT

  typedef logic [NUM_T-1:0]     tstate_t;
  typedef logic [NUM_INSTR-1:0] instr_t;
  typedef logic [OPC_W-1:0]     opcode_t;

  localparam tstate_t TSTATE_T0 = tstate_t'(1);
  localparam tstate_t TSTATE_T4 = tstate_t'(1) << T_HALT;

  // Opcode values (8085 encoding)
  localparam opcode_t OPC_NOP     = 8'h00;
  localparam opcode_t OPC_RAL     = 8'h17;
  localparam opcode_t OPC_RAR     = 8'h1F;
  localparam opcode_t OPC_STA     = 8'h32;
  localparam opcode_t OPC_LDA     = 8'h3A;
  localparam opcode_t OPC_INR_A   = 8'h3C;
  localparam opcode_t OPC_DCR_A   = 8'h3D;
  localparam opcode_t OPC_MVI_A   = 8'h3E;
  localparam opcode_t OPC_MOV_B_A = 8'h47;
  localparam opcode_t OPC_MOV_C_A = 8'h4F;
  localparam opcode_t OPC_HLT     = 8'h76;
  localparam opcode_t OPC_MOV_A_B = 8'h78;
  localparam opcode_t OPC_MOV_A_C = 8'h79;
  localparam opcode_t OPC_ADD_B   = 8'h80;
  localparam opcode_t OPC_ADD_C   = 8'h81;
  localparam opcode_t OPC_SUB_B   = 8'h90;
  localparam opcode_t OPC_SUB_C   = 8'h91;
  localparam opcode_t OPC_ANA_B   = 8'hA0;
  localparam opcode_t OPC_ANA_C   = 8'hA1;
  localparam opcode_t OPC_XRA_B   = 8'hA8;
  localparam opcode_t OPC_XRA_C   = 8'hA9;
  localparam opcode_t OPC_ORA_B   = 8'hB0;
  localparam opcode_t OPC_ORA_C   = 8'hB1;
  localparam opcode_t OPC_JMP     = 8'hC3;
  localparam opcode_t OPC_RET     = 8'hC9;
  localparam opcode_t OPC_JZ      = 8'hCA;
  localparam opcode_t OPC_CALL    = 8'hCD;
  localparam opcode_t OPC_OUT     = 8'hD3;
  localparam opcode_t OPC_IN      = 8'hDB;

  // Instruction-line indices, alphabetical
  localparam int INSTR_ADD_B   = 0;
  localparam int INSTR_ADD_C   = 1;
  localparam int INSTR_ANA_B   = 2;
  localparam int INSTR_ANA_C   = 3;
  localparam int INSTR_CALL    = 4;
  localparam int INSTR_DCR_A   = 5;
  localparam int INSTR_HLT     = 6;
  localparam int INSTR_IN      = 7;
  localparam int INSTR_INR_A   = 8;
  localparam int INSTR_JMP     = 9;
  localparam int INSTR_JZ      = 10;
  localparam int INSTR_LDA     = 11;
  localparam int INSTR_MOV_A_B = 12;
  localparam int INSTR_MOV_A_C = 13;
  localparam int INSTR_MOV_B_A = 14;
  localparam int INSTR_MOV_C_A = 15;
  localparam int INSTR_MVI_A   = 16;
  localparam int INSTR_NOP     = 17;
  localparam int INSTR_ORA_B   = 18;
  localparam int INSTR_ORA_C   = 19;
  localparam int INSTR_OUT     = 20;
  localparam int INSTR_RAL     = 21;
  localparam int INSTR_RAR     = 22;
  localparam int INSTR_RET     = 23;
  localparam int INSTR_STA     = 24;
  localparam int INSTR_SUB_B   = 25;
  localparam int INSTR_SUB_C   = 26;
  localparam int INSTR_XRA_B   = 27;
  localparam int INSTR_XRA_C   = 28;

endpackage

// File: rtl/sap2_opcode_decoder.sv
// sap2_opcode_decoder: pure combinational IR -> one-hot instruction lines.
// Undefined opcodes raise the NOP line (so the matrix ends the instruction
// at T3) and flag illegal.
module sap2_opcode_decoder
  import sap2_pkg::*;
(
  input  logic [OPC_W-1:0]     ir,
  output logic [NUM_INSTR-1:0] instr,
  output logic                 illegal
);

  // Map the instruction register onto exactly one instruction line.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    instr   = '0;
    illegal = 1'b0;
    case (ir)
      OPC_NOP:     instr[INSTR_NOP]     = 1'b1;
      OPC_RAL:     instr[INSTR_RAL]     = 1'b1;
      OPC_RAR:     instr[INSTR_RAR]     = 1'b1;
      OPC_STA:     instr[INSTR_STA]     = 1'b1;
      OPC_LDA:     instr[INSTR_LDA]     = 1'b1;
      OPC_INR_A:   instr[INSTR_INR_A]   = 1'b1;
      OPC_DCR_A:   instr[INSTR_DCR_A]   = 1'b1;
      OPC_MVI_A:   instr[INSTR_MVI_A]   = 1'b1;
      OPC_MOV_B_A: instr[INSTR_MOV_B_A] = 1'b1;
      OPC_MOV_C_A: instr[INSTR_MOV_C_A] = 1'b1;
      OPC_HLT:     instr[INSTR_HLT]     = 1'b1;
      OPC_MOV_A_B: instr[INSTR_MOV_A_B] = 1'b1;
      OPC_MOV_A_C: instr[INSTR_MOV_A_C] = 1'b1;
      OPC_ADD_B:   instr[INSTR_ADD_B]   = 1'b1;
      OPC_ADD_C:   instr[INSTR_ADD_C]   = 1'b1;
      OPC_SUB_B:   instr[INSTR_SUB_B]   = 1'b1;
      OPC_SUB_C:   instr[INSTR_SUB_C]   = 1'b1;
      OPC_ANA_B:   instr[INSTR_ANA_B]   = 1'b1;
      OPC_ANA_C:   instr[INSTR_ANA_C]   = 1'b1;
      OPC_XRA_B:   instr[INSTR_XRA_B]   = 1'b1;
      OPC_XRA_C:   instr[INSTR_XRA_C]   = 1'b1;
      OPC_ORA_B:   instr[INSTR_ORA_B]   = 1'b1;
      OPC_ORA_C:   instr[INSTR_ORA_C]   = 1'b1;
      OPC_JMP:     instr[INSTR_JMP]     = 1'b1;
      OPC_RET:     instr[INSTR_RET]     = 1'b1;
      OPC_JZ:      instr[INSTR_JZ]      = 1'b1;
      OPC_CALL:    instr[INSTR_CALL]    = 1'b1;
      OPC_OUT:     instr[INSTR_OUT]     = 1'b1;
      OPC_IN:      instr[INSTR_IN]      = 1'b1;
      default: begin
        instr[INSTR_NOP] = 1'b1;
        illegal          = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sap2_tstate_sequencer.sv
// sap2_tstate_sequencer: SAP-2 control-unit front end.
// 18-state one-hot T-state ring, instruction register, opcode decode, zero flag,
// halt freeze and sticky illegal-opcode / ring-overrun indicators.
// Optional build macro SAP2_SINGLE_STEP_EN adds iStep; state then advances only
// on edges where iStep=1 (reset still asynchronous).
module sap2_tstate_sequencer
  import sap2_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [OPC_W-1:0]     iBus,
  input  logic                 iLir,
  input  logic                 iRingReset,
  input  logic                 iLoadFlag,
  input  logic                 iZeroIn,
`ifdef SAP2_SINGLE_STEP_EN
  input  logic                 iStep,
`endif
  output logic [NUM_T-1:0]     oTstate,
  output logic [NUM_INSTR-1:0] oInstr,
  output logic                 oZeroFlag,
  output logic                 oHalted,
  output logic                 oIllegal,
  output logic                 oSeqError
);

  opcode_t ir;
  logic    dec_illegal;
  logic    illegal_q;
  logic    advance;
  logic    in_decode;
  logic    halting;

`ifdef SAP2_SINGLE_STEP_EN
  assign advance = iStep && !oHalted;
`else
  assign advance = !oHalted;
`endif

  assign in_decode = oTstate[T_DECODE];
  assign halting   = in_decode && oInstr[INSTR_HLT];

  sap2_opcode_decoder u_decoder (
    .ir      (ir),
    .instr   (oInstr),
    .illegal (dec_illegal)
  );

  // Illegal is visible during T3 itself and then held by the sticky register.
  assign oIllegal = illegal_q || (in_decode && dec_illegal);

  // Ring counter, IR, zero flag, halt and sticky status bits.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oTstate   <= TSTATE_T0;
      ir        <= OPC_NOP;
      oZeroFlag <= 1'b0;
      oHalted   <= 1'b0;
      illegal_q <= 1'b0;
      oSeqError <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values; blocking would let later lines see updated state.
      if (halting) begin
        oTstate <= TSTATE_T4;
        oHalted <= 1'b1;
      end else if (iRingReset) begin
        oTstate <= TSTATE_T0;
      end else begin
        oTstate <= {oTstate[NUM_T-2:0], oTstate[NUM_T-1]};
        if (oTstate[NUM_T-1]) oSeqError <= 1'b1;
      end

      // Keep HLT in the IR once halting so the decode stays consistent.
      if (iLir && !halting) ir <= iBus;

      if (in_decode && dec_illegal) illegal_q <= 1'b1;

      if (iLoadFlag) oZeroFlag <= iZeroIn;
    end
  end

endmodule

// File: tb/tb_sap2_tstate_sequencer.sv
// tb_sap2_tstate_sequencer: directed stimulus with a scoreboard queue.
// Stimulus pushes the expected output word after each action; a monitor pops
// and compares on every falling edge while expectations are pending.
`timescale 1ns/1ps
module tb_sap2_tstate_sequencer;
  import sap2_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [OPC_W-1:0]     bus = '0;
  logic                 lir = 1'b0;
  logic                 ring_reset = 1'b0;
  logic                 load_flag = 1'b0;
  logic                 zero_in = 1'b0;
  logic [NUM_T-1:0]     tstate;
  logic [NUM_INSTR-1:0] instr;
  logic                 zero_flag, halted, illegal, seq_error;
`ifdef SAP2_SINGLE_STEP_EN
  logic                 step_en = 1'b1;
`endif

  sap2_tstate_sequencer dut (
    .iClk       (clk),
    .iRst       (rst),
    .iBus       (bus),
    .iLir       (lir),
    .iRingReset (ring_reset),
    .iLoadFlag  (load_flag),
    .iZeroIn    (zero_in),
`ifdef SAP2_SINGLE_STEP_EN
    .iStep      (step_en),
`endif
    .oTstate    (tstate),
    .oInstr     (instr),
    .oZeroFlag  (zero_flag),
    .oHalted    (halted),
    .oIllegal   (illegal),
    .oSeqError  (seq_error)
  );

  always #5 clk = ~clk;

  string            name_q[$];
  logic [50:0]      exp_q[$];
  int               total = 0;
  int               bad   = 0;

  // Expected output word: {tstate, instr, zero, halted, illegal, seq_error}
  function automatic logic [50:0] mk(input int t, input int ins, input logic zf,
                                     input logic h, input logic il, input logic se);
    logic [NUM_T-1:0]     ts;
    logic [NUM_INSTR-1:0] in;
    ts = '0;
    in = '0;
    ts[t]   = 1'b1;
    in[ins] = 1'b1;
    return {ts, in, zf, h, il, se};
  endfunction

  task automatic check(input string nm, input logic [50:0] got, input logic [50:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got ts=%h instr=%h z/h/ill/se=%b, want ts=%h instr=%h z/h/ill/se=%b",
               nm, got[50:33], got[32:4], got[3:0], want[50:33], want[32:4], want[3:0]);
    end
  endtask

  task automatic push(input string nm, input logic [50:0] v);
    name_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  // Monitor: one pending expectation is compared per falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0)
        check(name_q.pop_front(), {tstate, instr, zero_flag, halted, illegal, seq_error},
              exp_q.pop_front());
    end
  end

  // Drive one cycle of inputs, clock it, then return inputs to idle.
  task automatic step(input logic rr, input logic ld, input logic [7:0] b,
                      input logic lf, input logic zin);
    ring_reset = rr;
    lir        = ld;
    bus        = b;
    load_flag  = lf;
    zero_in    = zin;
    @(posedge clk);
    #1;
    ring_reset = 1'b0;
    lir        = 1'b0;
    load_flag  = 1'b0;
    zero_in    = 1'b0;
  endtask

  // Assert reset in the middle of a cycle and expect reset values immediately.
  task automatic apply_reset(input string nm);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 push(nm, mk(0, INSTR_NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state, then free-running ring T1..T5
    apply_reset("reset_state");
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      push($sformatf("ring_T%0d", k), mk(k, INSTR_NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // ADD B fetched in T2, ring reset in T4
    apply_reset("reset_before_add");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push("add_T2", mk(2, INSTR_NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    push("add_T3_decode", mk(3, INSTR_ADD_B, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push("add_T4", mk(4, INSTR_ADD_B, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    push("add_ring_reset_T0", mk(0, INSTR_ADD_B, 1'b0, 1'b0, 1'b0, 1'b0));

    // Overrun: T0 -> T17 -> T0 without ring reset sets sticky seq error
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      push($sformatf("wrap_T%0d", k), mk(k, INSTR_ADD_B, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push("wrap_T0_seqerr", mk(0, INSTR_ADD_B, 1'b0, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push("seqerr_sticky", mk(1, INSTR_ADD_B, 1'b0, 1'b0, 1'b0, 1'b1));

    // HLT: freeze at T4, ignore ring reset / IR load / flag load
    apply_reset("reset_clears_seqerr");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h76, 1'b0, 1'b0);
    push("hlt_T3_decode", mk(3, INSTR_HLT, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push("hlt_halted_T4", mk(4, INSTR_HLT, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
      push($sformatf("hlt_frozen_%0d", k), mk(4, INSTR_HLT, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    apply_reset("reset_exits_halt");

    // Undefined opcode 0xFF: NOP line, illegal in T3, sticky afterwards
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    push("illegal_T3", mk(3, INSTR_NOP, 1'b0, 1'b0, 1'b1, 1'b0));
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    push("illegal_sticky_T0", mk(0, INSTR_NOP, 1'b0, 1'b0, 1'b1, 1'b0));
    apply_reset("reset_clears_illegal");

    // Zero flag load, hold, async clear
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    push("zflag_load", mk(1, INSTR_NOP, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push("zflag_hold", mk(2, INSTR_NOP, 1'b1, 1'b0, 1'b0, 1'b0));
    apply_reset("zflag_async_clear");

    // IR load and ring reset on the same edge both take effect
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h3A, 1'b0, 1'b0);
    push("lir_with_ring_reset", mk(0, INSTR_LDA, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push("lda_T1", mk(1, INSTR_LDA, 1'b0, 1'b0, 1'b0, 1'b0));

`ifdef SAP2_SINGLE_STEP_EN
    step_en = 1'b0;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    push("step_low_holds", mk(1, INSTR_LDA, 1'b0, 1'b0, 1'b0, 1'b0));
    step_en = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push("step_pulse_shift", mk(2, INSTR_LDA, 1'b0, 1'b0, 1'b0, 1'b0));
`endif

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
